// File: rtl/toggle_pulse_gen.sv
// Push-button conditioner: synchronizes and debounces a raw button and emits a
// single-cycle toggle pulse per accepted press, with optional auto-repeat while held.
module toggle_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned REPEAT_CYCLES   = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_in,
  output logic       t,
  output logic       btn_level,
  output logic [7:0] press_count
);

  localparam int unsigned PCNT_W = 8;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit RPT_EN = (REPEAT_CYCLES != 0);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(RPT_EN ? (REPEAT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                s_q, s_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    rpt_q, rpt_d;
  logic                t_q, t_d;
  logic                lvl_q, lvl_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;

  // Next-state and registered-output logic
  always_comb begin
    sync1_d = btn_in;
    s_d     = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;
    t_d     = 1'b0;
    pcnt_d  = pcnt_q;

    case (state_q)
      IDLE: begin
        if (s_q) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (!s_q) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          t_d     = 1'b1;
          pcnt_d  = pcnt_q + PCNT_W'(1);
          rpt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s_q) begin
          state_d = REL_DB;
          cnt_d   = '0;
        end else if (RPT_EN) begin
          if (rpt_q == RPT_LAST) begin
            t_d    = 1'b1;
            pcnt_d = pcnt_q + PCNT_W'(1);
            rpt_d  = '0;
          end else begin
            rpt_d = rpt_q + CNT_W'(1);
          end
        end
      end
      REL_DB: begin
        // A return to 1 is release bounce: resume HELD with the repeat phase intact
        if (s_q) begin
          state_d = HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    lvl_d = (state_d == HELD) || (state_d == REL_DB);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      rpt_q   <= '0;
      t_q     <= 1'b0;
      lvl_q   <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      s_q     <= s_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
      t_q     <= t_d;
      lvl_q   <= lvl_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign t           = t_q;
  assign btn_level   = lvl_q;
  assign press_count = pcnt_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Scoreboard bench for toggle_pulse_gen: expected pulse cycles/counts are queued
// when the button is driven and matched against observed t pulses.
module tb_toggle_pulse_gen;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn;
  logic       btn_r;
  logic       t, btn_level;
  logic [7:0] press_count;
  logic       t_r, btn_level_r;
  logic [7:0] press_count_r;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_toggle = 0;
  logic [7:0] exp_main = '0;
  logic [7:0] exp_rpt = '0;
  exp_t       q_main[$];
  exp_t       q_rpt[$];
  exp_t       e_main, e_rpt;
  logic       t_prev = 1'b0;
  logic       t_prev_r = 1'b0;
  logic       tff_q, tff_prev = 1'b0;

  toggle_pulse_gen u_dut (
    .clock       (clock),
    .reset       (reset),
    .btn_in      (btn),
    .t           (t),
    .btn_level   (btn_level),
    .press_count (press_count)
  );

  toggle_pulse_gen #(.REPEAT_CYCLES(10)) u_rpt (
    .clock       (clock),
    .reset       (reset),
    .btn_in      (btn_r),
    .t           (t_r),
    .btn_level   (btn_level_r),
    .press_count (press_count_r)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Downstream toggle flop fed by t
  always @(posedge clock or posedge reset) begin
    if (reset) tff_q <= 1'b0;
    else if (t) tff_q <= ~tff_q;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push_main(input int at);
    exp_main = exp_main + 8'd1;
    q_main.push_back('{at, exp_main});
  endtask

  task automatic push_rpt(input int at);
    exp_rpt = exp_rpt + 8'd1;
    q_rpt.push_back('{at, exp_rpt});
  endtask

  // Press, hold, release; checks the debounced level falls exactly 7 edges after the drop
  task automatic press(input int hold, input int rel);
    @(negedge clock);
    btn = 1'b1;
    push_main(cyc + 7);
    repeat (hold) @(negedge clock);
    btn = 1'b0;
    repeat (6) @(negedge clock);
    check("level_before_fall", btn_level, 1);
    @(negedge clock);
    check("level_fall", btn_level, 0);
    repeat (rel - 7) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (t) begin
      if (q_main.size() == 0) begin
        check("main_t_unexpected", t, 0);
      end else begin
        e_main = q_main.pop_front();
        check("main_t_cycle", cyc, e_main.cyc);
        check("main_t_count", press_count, e_main.cnt);
        check("main_t_level", btn_level, 1);
        check("main_t_gap", t_prev, 0);
      end
    end else if (q_main.size() > 0 && q_main[0].cyc <= cyc) begin
      void'(q_main.pop_front());
      check("main_t_missing", t, 1);
    end
    t_prev <= t;
    if (tff_q != tff_prev) n_toggle++;
    tff_prev <= tff_q;
  end

  always @(negedge clock) begin
    if (t_r) begin
      if (q_rpt.size() == 0) begin
        check("rpt_t_unexpected", t_r, 0);
      end else begin
        e_rpt = q_rpt.pop_front();
        check("rpt_t_cycle", cyc, e_rpt.cyc);
        check("rpt_t_count", press_count_r, e_rpt.cnt);
        check("rpt_t_gap", t_prev_r, 0);
      end
    end else if (q_rpt.size() > 0 && q_rpt[0].cyc <= cyc) begin
      void'(q_rpt.pop_front());
      check("rpt_t_missing", t_r, 1);
    end
    t_prev_r <= t_r;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pat[7];
    int n0;
    pat = '{1, 1, 0, 1, 0, 0, 1};
    reset = 1'b1;
    btn   = 1'b0;
    btn_r = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_t", t, 0);
    check("rst_level", btn_level, 0);
    check("rst_count", press_count, 0);
    check("rst_count_rpt", press_count_r, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // 1: clean press
    press(20, 20);
    check("t1_count", press_count, 1);

    // 2: bounce on the way in, then a stable hold
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      btn = pat[i][0];
      if (i == 6) push_main(cyc + 7);
    end
    repeat (15) @(negedge clock);
    btn = 1'b0;
    repeat (15) @(negedge clock);
    check("t2_count", press_count, 2);

    // 3: release bounce while held
    @(negedge clock);
    btn = 1'b1;
    push_main(cyc + 7);
    repeat (12) @(negedge clock);
    btn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (i == 1) btn = 1'b1;
      check("t3_level_held", btn_level, 1);
    end
    btn = 1'b0;
    repeat (15) @(negedge clock);
    check("t3_count", press_count, 3);

    // 4: auto-repeat every 10 cycles
    @(negedge clock);
    btn_r = 1'b1;
    n0 = cyc;
    for (int k = 0; k < 6; k++) push_rpt(n0 + 7 + 10 * k);
    repeat (57) @(negedge clock);
    btn_r = 1'b0;
    repeat (15) @(negedge clock);
    check("t4_count", press_count_r, 6);

    // 5: reset mid press-debounce with the button still held
    @(negedge clock);
    btn = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    check("t5_rst_t", t, 0);
    check("t5_rst_level", btn_level, 0);
    check("t5_rst_count", press_count, 0);
    check("t5_rst_count_rpt", press_count_r, 0);
    exp_main = '0;
    exp_rpt  = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    push_main(cyc + 7);
    repeat (12) @(negedge clock);
    btn = 1'b0;
    repeat (15) @(negedge clock);
    check("t5_count", press_count, 1);

    // 6: 256 presses wrap the counter and toggle the downstream flop 256 times
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_main = '0;
    @(negedge clock);
    n_toggle = 0;
    for (int p = 0; p < 256; p++) press(10, 10);
    repeat (3) @(negedge clock);
    check("t6_count_wrap", press_count, 0);
    check("t6_tff_q", tff_q, 0);
    check("t6_toggles", n_toggle, 256);

    check("q_main_empty", q_main.size(), 0);
    check("q_rpt_empty", q_rpt.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
